// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter slice.
// Contents:
//   DATA_W / OP_W  - ALU operand and control-code widths
//   alu_op_e       - ALU control encodings (codes above LUI are undefined)
//   ALU_OP_LAST    - highest defined control code
//   op_legal()     - true when a control code has a defined ALU result
package alu_pkg;

  localparam int DATA_W = 32;
  localparam int OP_W   = 4;

  typedef enum logic [OP_W-1:0] {
    ADD  = 4'd0,
    SUB  = 4'd1,
    SLL  = 4'd2,
    SLT  = 4'd3,
    AND  = 4'd4,
    OR   = 4'd5,
    XOR  = 4'd6,
    SRL  = 4'd7,
    SRA  = 4'd8,
    SLTU = 4'd9,
    LUI  = 4'd10
  } alu_op_e;

  localparam logic [OP_W-1:0] ALU_OP_LAST = 4'd10;

  function automatic logic op_legal(input logic [OP_W-1:0] op);
    return op <= ALU_OP_LAST;
  endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Bundle of the requester channels, the ALU drive/return and the response
// channel of the ALU arbiter.
//   req_valid/req_ready : per-requester handshake (NUM_REQ bits)
//   req_a/req_b/req_op  : packed per-requester operands and control code
//   alu_a/alu_b/alu_ctrl: operands and code driven to the shared ALU
//   alu_out             : combinational ALU result
//   rsp_*               : one-entry response register and its handshake
// Modports: slave = arbiter side, master = requesters/ALU/consumer side.
interface alu_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 1
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ*32-1:0] req_a;
  logic [NUM_REQ*32-1:0] req_b;
  logic [NUM_REQ*4-1:0]  req_op;
  logic [31:0]           alu_a;
  logic [31:0]           alu_b;
  logic [3:0]            alu_ctrl;
  logic [31:0]           alu_out;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [31:0]           rsp_data;
  logic [ID_W-1:0]       rsp_id;
  logic                  rsp_err;

  modport slave (
    input  req_valid, req_a, req_b, req_op, alu_out, rsp_ready,
    output req_ready, alu_a, alu_b, alu_ctrl, rsp_valid, rsp_data, rsp_id, rsp_err
  );

  modport master (
    output req_valid, req_a, req_b, req_op, alu_out, rsp_ready,
    input  req_ready, alu_a, alu_b, alu_ctrl, rsp_valid, rsp_data, rsp_id, rsp_err
  );
endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with a registered priority pointer.
//   clk, rst_n : clock, asynchronous active-low reset (pointer -> 0)
//   req[N]     : request vector
//   en         : grants are allowed this cycle
//   gnt[N]     : one-hot grant (all zero when en=0 or no request)
//   gnt_idx    : index of the granted requester
// The scan starts at rr_ptr and wraps; the pointer moves past the winner
// only when a grant is actually issued.
module rr_arbiter #(
  parameter int  N  = 2,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  input  logic          en,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);

  logic [IW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IW-1:0] idx;
  logic          found;

  always_comb begin
    gnt      = '0;
    gnt_idx  = '0;
    idx      = '0;
    found    = 1'b0;
    rr_ptr_d = rr_ptr_q;
    if (en) begin
      for (int off = 0; off < N; off++) begin
        idx = IW'((int'(rr_ptr_q) + off) % N);
        if (!found && req[idx]) begin
          found      = 1'b1;
          gnt[idx]   = 1'b1;
          gnt_idx    = idx;
        end
      end
    end
    if (found) begin
      rr_ptr_d = (gnt_idx == IW'(N - 1)) ? '0 : gnt_idx + IW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one single-cycle ALU between NUM_REQ requesters.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : alu_arbiter_if slave modport (request channels, ALU drive
//                and return, response register with id and error flag)
// A round-robin winner drives the ALU combinationally; its result is
// captured in a one-entry response register the following edge. The
// register may be refilled in the same cycle it drains, giving one result
// per cycle while rsp_ready stays high.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 1
) (
  input logic          clk,
  input logic          rst_n,
  alu_arbiter_if.slave bus
);

  logic [NUM_REQ-1:0] gnt;
  logic [ID_W-1:0]    gnt_idx;
  logic               can_issue;

  logic [DATA_W-1:0]  alu_a_c, alu_b_c;
  logic [OP_W-1:0]    alu_ctrl_c;

  logic               rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]  rsp_data_q,  rsp_data_d;
  logic [ID_W-1:0]    rsp_id_q,    rsp_id_d;
  logic               rsp_err_q,   rsp_err_d;

  assign can_issue = !rsp_valid_q || bus.rsp_ready;

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (bus.req_valid),
    .en      (can_issue),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  // With no grant the ALU sees zeros (ADD 0+0) so it stays quiet.
  always_comb begin
    alu_a_c    = '0;
    alu_b_c    = '0;
    alu_ctrl_c = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        alu_a_c    = bus.req_a[DATA_W*i +: DATA_W];
        alu_b_c    = bus.req_b[DATA_W*i +: DATA_W];
        alu_ctrl_c = bus.req_op[OP_W*i +: OP_W];
      end
    end
  end

  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_id_d    = rsp_id_q;
    rsp_err_d   = rsp_err_q;
    if (|gnt) begin
      rsp_valid_d = 1'b1;
      rsp_id_d    = gnt_idx;
      // The ALU output is undefined for codes past LUI; report zero + error.
      if (op_legal(alu_ctrl_c)) begin
        rsp_data_d = bus.alu_out;
        rsp_err_d  = 1'b0;
      end else begin
        rsp_data_d = '0;
        rsp_err_d  = 1'b1;
      end
    end else if (rsp_valid_q && bus.rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_id_q    <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_id_q    <= rsp_id_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign bus.req_ready = gnt;
  assign bus.alu_a     = alu_a_c;
  assign bus.alu_b     = alu_b_c;
  assign bus.alu_ctrl  = alu_ctrl_c;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Testbench for alu_arbiter with two requesters and a behavioural ALU.
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int NUM_REQ = 2;
  localparam int ID_W    = 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_arbiter_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) intf ();

  alu_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (intf)
  );

  function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] op);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a << b[4:0];
      4'd3:    return {31'b0, $signed(a) < $signed(b)};
      4'd4:    return a & b;
      4'd5:    return a | b;
      4'd6:    return a ^ b;
      4'd7:    return a >> b[4:0];
      4'd8:    return 32'($signed(a) >>> b[4:0]);
      4'd9:    return {31'b0, a < b};
      4'd10:   return b;
      default: return 32'hDEADBEEF;  // undefined codes: garbage from the ALU
    endcase
  endfunction

  assign intf.alu_out = ref_alu(intf.alu_a, intf.alu_b, intf.alu_ctrl);

  typedef struct packed {
    logic [31:0]     data;
    logic [ID_W-1:0] id;
    logic            err;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic set_req(input int i, input logic v, input logic [31:0] a,
                         input logic [31:0] b, input logic [3:0] op);
    intf.req_valid[i]       = v;
    intf.req_a[32*i +: 32]  = a;
    intf.req_b[32*i +: 32]  = b;
    intf.req_op[4*i +: 4]   = op;
  endtask

  // Expected response for a grant to requester i, from its driven operands.
  task automatic push_exp(input int i);
    exp_t x;
    logic [31:0] a, b;
    logic [3:0]  op;
    a  = intf.req_a[32*i +: 32];
    b  = intf.req_b[32*i +: 32];
    op = intf.req_op[4*i +: 4];
    x.id = ID_W'(i);
    if (op > 4'd10) begin
      x.data = 32'd0;
      x.err  = 1'b1;
    end else begin
      x.data = ref_alu(a, b, op);
      x.err  = 1'b0;
    end
    exp_q.push_back(x);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_q.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    n_checks++; if (intf.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", intf.rsp_valid); end
    n_checks++; if (intf.rsp_data !== 32'd0) begin n_fail++; $display("FAIL reset_data: got %h want 0", intf.rsp_data); end
    n_checks++; if (intf.rsp_id !== '0) begin n_fail++; $display("FAIL reset_id: got %0d want 0", intf.rsp_id); end
    n_checks++; if (intf.rsp_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", intf.rsp_err); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    n_checks++; if (intf.req_ready !== 2'b00) begin n_fail++; $display("FAIL idle_ready: got %b want 00", intf.req_ready); end
    n_checks++; if (intf.alu_ctrl !== 4'd0 || intf.alu_a !== 32'd0) begin n_fail++; $display("FAIL idle_alu: got ctrl=%0d a=%h want 0 0", intf.alu_ctrl, intf.alu_a); end
  endtask

  task automatic test_single();
    intf.rsp_ready = 1'b1;
    set_req(0, 1'b1, 32'd5, 32'd3, SUB);
    #1;
    n_checks++; if (intf.req_ready !== 2'b01) begin n_fail++; $display("FAIL single_grant: got %b want 01", intf.req_ready); end
    push_exp(0);
    @(posedge clk); #1;
    set_req(0, 1'b0, 32'd0, 32'd0, ADD);
    if (exp_q.size() == 0) begin n_checks++; n_fail++; $display("FAIL single_sb: got empty queue want entry"); end
    else begin
      e = exp_q.pop_front(); n_checks++;
      if (intf.rsp_valid !== 1'b1 || intf.rsp_data !== e.data || intf.rsp_id !== e.id || intf.rsp_err !== e.err) begin
        n_fail++; $display("FAIL single_rsp: got v=%b d=%h id=%0d err=%b want v=1 d=%h id=%0d err=%b",
                           intf.rsp_valid, intf.rsp_data, intf.rsp_id, intf.rsp_err, e.data, e.id, e.err);
      end
    end
    n_checks++; if (intf.rsp_data !== 32'd2) begin n_fail++; $display("FAIL single_data: got %h want 2", intf.rsp_data); end
    @(posedge clk); #1;
    n_checks++; if (intf.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL drain_valid: got %b want 0", intf.rsp_valid); end
    n_checks++; if (intf.rsp_data !== 32'd2 || intf.rsp_id !== 1'b0) begin n_fail++; $display("FAIL drain_hold: got d=%h id=%0d want 2 0", intf.rsp_data, intf.rsp_id); end
  endtask

  task automatic test_contention();
    do_reset();
    intf.rsp_ready = 1'b1;
    set_req(0, 1'b1, 32'd1, 32'd1, ADD);
    set_req(1, 1'b1, 32'hF0, 32'h0F, XOR);
    for (int k = 0; k < 4; k++) begin
      #1;
      n_checks++; if (intf.req_ready !== ((k % 2 == 1) ? 2'b10 : 2'b01)) begin n_fail++; $display("FAIL cont_grant%0d: got %b want %b", k, intf.req_ready, (k % 2 == 1) ? 2'b10 : 2'b01); end
      push_exp(k % 2);
      @(posedge clk); #1;
      if (exp_q.size() == 0) begin n_checks++; n_fail++; $display("FAIL cont_sb%0d: got empty queue want entry", k); end
      else begin
        e = exp_q.pop_front(); n_checks++;
        if (intf.rsp_valid !== 1'b1 || intf.rsp_data !== e.data || intf.rsp_id !== e.id || intf.rsp_err !== e.err) begin
          n_fail++; $display("FAIL cont_rsp%0d: got v=%b d=%h id=%0d err=%b want v=1 d=%h id=%0d err=%b", k,
                             intf.rsp_valid, intf.rsp_data, intf.rsp_id, intf.rsp_err, e.data, e.id, e.err);
        end
      end
      n_checks++; if (intf.rsp_data !== ((k % 2 == 1) ? 32'hFF : 32'd2)) begin n_fail++; $display("FAIL cont_data%0d: got %h want %h", k, intf.rsp_data, (k % 2 == 1) ? 32'hFF : 32'd2); end
    end
    set_req(0, 1'b0, 32'd0, 32'd0, ADD);
    set_req(1, 1'b0, 32'd0, 32'd0, ADD);
  endtask

  task automatic test_backpressure();
    set_req(0, 1'b1, 32'd10, 32'd20, ADD);
    #1;
    n_checks++; if (intf.req_ready !== 2'b01) begin n_fail++; $display("FAIL bp_first_grant: got %b want 01", intf.req_ready); end
    push_exp(0);
    @(posedge clk); #1;
    if (exp_q.size() == 0) begin n_checks++; n_fail++; $display("FAIL bp_sb0: got empty queue want entry"); end
    else begin
      e = exp_q.pop_front(); n_checks++;
      if (intf.rsp_valid !== 1'b1 || intf.rsp_data !== e.data || intf.rsp_id !== e.id || intf.rsp_err !== e.err) begin
        n_fail++; $display("FAIL bp_rsp0: got v=%b d=%h id=%0d err=%b want v=1 d=%h id=%0d err=%b",
                           intf.rsp_valid, intf.rsp_data, intf.rsp_id, intf.rsp_err, e.data, e.id, e.err);
      end
    end
    intf.rsp_ready = 1'b0;
    set_req(1, 1'b1, 32'd100, 32'd1, SUB);
    for (int k = 0; k < 3; k++) begin
      #1;
      n_checks++; if (intf.req_ready !== 2'b00) begin n_fail++; $display("FAIL bp_ready%0d: got %b want 00", k, intf.req_ready); end
      @(posedge clk); #1;
      n_checks++; if (intf.rsp_valid !== 1'b1 || intf.rsp_data !== 32'd30 || intf.rsp_id !== 1'b0) begin
        n_fail++; $display("FAIL bp_hold%0d: got v=%b d=%h id=%0d want 1 1e 0", k, intf.rsp_valid, intf.rsp_data, intf.rsp_id);
      end
    end
    intf.rsp_ready = 1'b1;
    #1;
    n_checks++; if (intf.req_ready !== 2'b10) begin n_fail++; $display("FAIL bp_resume_grant: got %b want 10", intf.req_ready); end
    push_exp(1);
    @(posedge clk); #1;
    set_req(1, 1'b0, 32'd0, 32'd0, ADD);
    if (exp_q.size() == 0) begin n_checks++; n_fail++; $display("FAIL bp_sb1: got empty queue want entry"); end
    else begin
      e = exp_q.pop_front(); n_checks++;
      if (intf.rsp_valid !== 1'b1 || intf.rsp_data !== e.data || intf.rsp_id !== e.id || intf.rsp_err !== e.err) begin
        n_fail++; $display("FAIL bp_rsp1: got v=%b d=%h id=%0d err=%b want v=1 d=%h id=%0d err=%b",
                           intf.rsp_valid, intf.rsp_data, intf.rsp_id, intf.rsp_err, e.data, e.id, e.err);
      end
    end
    n_checks++; if (intf.rsp_data !== 32'd99) begin n_fail++; $display("FAIL bp_data1: got %h want 63", intf.rsp_data); end
    #1;
    n_checks++; if (intf.req_ready !== 2'b01) begin n_fail++; $display("FAIL bp_waiter_grant: got %b want 01", intf.req_ready); end
    push_exp(0);
    @(posedge clk); #1;
    set_req(0, 1'b0, 32'd0, 32'd0, ADD);
    if (exp_q.size() == 0) begin n_checks++; n_fail++; $display("FAIL bp_sb2: got empty queue want entry"); end
    else begin
      e = exp_q.pop_front(); n_checks++;
      if (intf.rsp_valid !== 1'b1 || intf.rsp_data !== e.data || intf.rsp_id !== e.id || intf.rsp_err !== e.err) begin
        n_fail++; $display("FAIL bp_rsp2: got v=%b d=%h id=%0d err=%b want v=1 d=%h id=%0d err=%b",
                           intf.rsp_valid, intf.rsp_data, intf.rsp_id, intf.rsp_err, e.data, e.id, e.err);
      end
    end
    @(posedge clk); #1;
    n_checks++; if (intf.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drain: got %b want 0", intf.rsp_valid); end
  endtask

  task automatic test_illegal();
    logic [3:0] ops [3];
    set_req(0, 1'b1, 32'd1234, 32'd5, 4'd12);
    #1;
    n_checks++; if (intf.req_ready !== 2'b01) begin n_fail++; $display("FAIL ill_grant: got %b want 01", intf.req_ready); end
    push_exp(0);
    @(posedge clk); #1;
    if (exp_q.size() == 0) begin n_checks++; n_fail++; $display("FAIL ill_sb: got empty queue want entry"); end
    else begin
      e = exp_q.pop_front(); n_checks++;
      if (intf.rsp_valid !== 1'b1 || intf.rsp_data !== e.data || intf.rsp_id !== e.id || intf.rsp_err !== e.err) begin
        n_fail++; $display("FAIL ill_rsp: got v=%b d=%h id=%0d err=%b want v=1 d=%h id=%0d err=%b",
                           intf.rsp_valid, intf.rsp_data, intf.rsp_id, intf.rsp_err, e.data, e.id, e.err);
      end
    end
    n_checks++; if (intf.rsp_err !== 1'b1 || intf.rsp_data !== 32'd0) begin n_fail++; $display("FAIL ill_err: got err=%b d=%h want 1 0", intf.rsp_err, intf.rsp_data); end
    set_req(0, 1'b1, 32'hFFFFFFFF, 32'd1, SLT);
    #1;
    push_exp(0);
    @(posedge clk); #1;
    n_checks++; if (intf.rsp_data !== 32'd1 || intf.rsp_err !== 1'b0) begin n_fail++; $display("FAIL slt_after_ill: got d=%h err=%b want 1 0", intf.rsp_data, intf.rsp_err); end
    void'(exp_q.pop_front());
    ops[0] = 4'd10; ops[1] = 4'd11; ops[2] = 4'd15;
    for (int k = 0; k < 3; k++) begin
      set_req(0, 1'b1, 32'h12345678, 32'h0ABCD000, ops[k]);
      #1;
      push_exp(0);
      @(posedge clk); #1;
      if (exp_q.size() == 0) begin n_checks++; n_fail++; $display("FAIL op_edge_sb%0d: got empty queue want entry", k); end
      else begin
        e = exp_q.pop_front(); n_checks++;
        if (intf.rsp_valid !== 1'b1 || intf.rsp_data !== e.data || intf.rsp_id !== e.id || intf.rsp_err !== e.err) begin
          n_fail++; $display("FAIL op_edge%0d: got v=%b d=%h id=%0d err=%b want v=1 d=%h id=%0d err=%b", ops[k],
                             intf.rsp_valid, intf.rsp_data, intf.rsp_id, intf.rsp_err, e.data, e.id, e.err);
        end
      end
    end
    set_req(0, 1'b0, 32'd0, 32'd0, ADD);
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    intf.rsp_ready = 1'b0;
    set_req(0, 1'b1, 32'd2, 32'd2, ADD);
    @(posedge clk); #1;
    n_checks++; if (intf.rsp_valid !== 1'b1 || intf.rsp_data !== 32'd4) begin n_fail++; $display("FAIL rmid_pre: got v=%b d=%h want 1 4", intf.rsp_valid, intf.rsp_data); end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (intf.rsp_valid !== 1'b0 || intf.rsp_data !== 32'd0 || intf.rsp_err !== 1'b0 || intf.rsp_id !== 1'b0) begin
      n_fail++; $display("FAIL rmid_async: got v=%b d=%h id=%0d err=%b want 0 0 0 0", intf.rsp_valid, intf.rsp_data, intf.rsp_id, intf.rsp_err);
    end
    exp_q.delete();
    intf.rsp_ready = 1'b1;
    set_req(1, 1'b1, 32'hF0, 32'h0F, XOR);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_checks++; if (intf.req_ready !== 2'b01) begin n_fail++; $display("FAIL rmid_first: got %b want 01", intf.req_ready); end
    push_exp(0);
    @(posedge clk); #1;
    if (exp_q.size() == 0) begin n_checks++; n_fail++; $display("FAIL rmid_sb: got empty queue want entry"); end
    else begin
      e = exp_q.pop_front(); n_checks++;
      if (intf.rsp_valid !== 1'b1 || intf.rsp_data !== e.data || intf.rsp_id !== e.id || intf.rsp_err !== e.err) begin
        n_fail++; $display("FAIL rmid_rsp: got v=%b d=%h id=%0d err=%b want v=1 d=%h id=%0d err=%b",
                           intf.rsp_valid, intf.rsp_data, intf.rsp_id, intf.rsp_err, e.data, e.id, e.err);
      end
    end
    set_req(0, 1'b0, 32'd0, 32'd0, ADD);
    set_req(1, 1'b0, 32'd0, 32'd0, ADD);
  endtask

  task automatic test_back_to_back();
    intf.rsp_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      set_req(1, 1'b1, 32'd1, 32'(k), SLL);
      #1;
      n_checks++; if (intf.req_ready !== 2'b10) begin n_fail++; $display("FAIL b2b_grant%0d: got %b want 10", k, intf.req_ready); end
      push_exp(1);
      @(posedge clk); #1;
      if (exp_q.size() == 0) begin n_checks++; n_fail++; $display("FAIL b2b_sb%0d: got empty queue want entry", k); end
      else begin
        e = exp_q.pop_front(); n_checks++;
        if (intf.rsp_valid !== 1'b1 || intf.rsp_data !== e.data || intf.rsp_id !== e.id || intf.rsp_err !== e.err) begin
          n_fail++; $display("FAIL b2b_rsp%0d: got v=%b d=%h id=%0d err=%b want v=1 d=%h id=%0d err=%b", k,
                             intf.rsp_valid, intf.rsp_data, intf.rsp_id, intf.rsp_err, e.data, e.id, e.err);
        end
      end
      n_checks++; if (intf.rsp_data !== (32'd1 << k)) begin n_fail++; $display("FAIL b2b_data%0d: got %h want %h", k, intf.rsp_data, 32'd1 << k); end
    end
    set_req(1, 1'b0, 32'd0, 32'd0, ADD);
    @(posedge clk); #1;
    n_checks++; if (intf.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drain: got %b want 0", intf.rsp_valid); end
  endtask

  initial begin
    intf.req_valid = '0;
    intf.req_a     = '0;
    intf.req_b     = '0;
    intf.req_op    = '0;
    intf.rsp_ready = 1'b0;
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_illegal();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
